// File: rtl/inst_cache_assoc.sv
// N-way set-associative instruction cache with LRU replacement, early restart and whole-cache flush.
// Optional INST_CACHE_PERF_EN adds saturating hit/miss counters (perf_hits, perf_misses).
module inst_cache_assoc #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int WAY_WIDTH    = 2,
  parameter int SET_WIDTH    = 3,
  parameter int OFFSET_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  input  logic                  flush,
  output logic                  flush_busy,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  input  logic                  mem_rlast
`ifdef INST_CACHE_PERF_EN
  ,
  output logic [31:0]           perf_hits,
  output logic [31:0]           perf_misses
`endif
);

  localparam int TAG_WIDTH = ADDR_WIDTH - SET_WIDTH - OFFSET_WIDTH;
  localparam int WAYS      = 1 << WAY_WIDTH;
  localparam int SETS      = 1 << SET_WIDTH;
  localparam int WORDS     = 1 << OFFSET_WIDTH;
  localparam int AW        = (WAY_WIDTH > 0) ? WAY_WIDTH : 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, FLUSH} state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0]   data_mem  [WAYS][SETS][WORDS];
  logic [TAG_WIDTH-1:0]    tag_mem   [WAYS][SETS];
  logic [WAYS-1:0]         valid_mem [SETS];
  logic [AW-1:0]           age_mem   [SETS][WAYS];

  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [TAG_WIDTH-1:0]    cur_tag;
  logic [SET_WIDTH-1:0]    cur_set;
  logic [OFFSET_WIDTH-1:0] cur_off;
  logic [OFFSET_WIDTH-1:0] cnt;
  logic                    served;
  logic [AW-1:0]           victim;
  logic [AW-1:0]           victim_nxt;
  logic                    victim_found;
  logic                    flush_pend;
  logic [SET_WIDTH-1:0]    flush_cnt;
  logic                    hit;
  logic [AW-1:0]           hit_way;
  logic [DATA_WIDTH-1:0]   hit_word;
  logic                    accept;
  logic                    beat;
  logic                    last_beat;
  logic                    restart;
  logic                    lru_en;
  logic [AW-1:0]           lru_way;

  assign cur_tag = addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign cur_set = addr_q[OFFSET_WIDTH +: SET_WIDTH];
  assign cur_off = addr_q[OFFSET_WIDTH-1:0];

  // Tag compare across all ways; at most one way can match a given tag.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_mem[cur_set][w] && (tag_mem[w][cur_set] == cur_tag)) begin
        hit     = 1'b1;
        hit_way = AW'(w);
      end
    end
  end

  assign hit_word = data_mem[hit_way][cur_set][cur_off];

  // Victim: lowest-index invalid way, otherwise the oldest way.
  always_comb begin
    victim_nxt   = '0;
    victim_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!victim_found && !valid_mem[cur_set][w]) begin
        victim_nxt   = AW'(w);
        victim_found = 1'b1;
      end
    end
    if (!victim_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_mem[cur_set][w] == AW'(WAYS - 1)) victim_nxt = AW'(w);
      end
    end
  end

  assign beat      = (state == REFILL) && mem_rvalid;
  assign last_beat = beat && mem_rlast;
  assign restart   = beat && (cnt == cur_off) && !served;
  assign lru_en    = ((state == LOOKUP) && hit) || last_beat;
  assign lru_way   = (state == LOOKUP) ? hit_way : victim;

  // Handshake: a request transfers on a cycle where req_valid and req_ready are both high;
  // each accepted request yields exactly one single-cycle resp_valid pulse.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    flush_busy = flush_pend || (state == FLUSH);
    case (state)
      IDLE: begin
        req_ready = !flush_pend && !flush;
        if (flush || flush_pend) state_nxt = FLUSH;
        else if (req_valid)      state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          resp_valid = 1'b1;
          resp_data  = hit_word;
          state_nxt  = IDLE;
        end else begin
          state_nxt  = REFILL;
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {addr_q[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
        if (restart) begin
          resp_valid = 1'b1;
          resp_data  = mem_rdata;
        end
        if (last_beat) state_nxt = IDLE;
      end
      FLUSH: begin
        if (flush_cnt == SET_WIDTH'(SETS - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      cnt        <= '0;
      served     <= 1'b0;
      victim     <= '0;
      flush_pend <= 1'b0;
      flush_cnt  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_mem[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_mem[s][w] <= AW'(w);
      end
`ifdef INST_CACHE_PERF_EN
      perf_hits   <= '0;
      perf_misses <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) addr_q <= req_addr;
      if (state == LOOKUP) begin
        victim <= victim_nxt;
        cnt    <= '0;
        served <= 1'b0;
      end
      if (beat)    cnt    <= cnt + 1'b1;
      if (restart) served <= 1'b1;
      // A flush seen while busy elsewhere is remembered; one seen during FLUSH is absorbed.
      if ((state == IDLE) && (flush || flush_pend)) flush_pend <= 1'b0;
      else if (flush && (state != FLUSH))           flush_pend <= 1'b1;
      if (state == IDLE) flush_cnt <= '0;
      if (state == FLUSH) begin
        valid_mem[flush_cnt] <= '0;
        flush_cnt            <= flush_cnt + 1'b1;
      end
      if (last_beat) valid_mem[cur_set][victim] <= 1'b1;
      if (lru_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (AW'(w) == lru_way)
            age_mem[cur_set][w] <= '0;
          else if (age_mem[cur_set][w] < age_mem[cur_set][lru_way])
            age_mem[cur_set][w] <= age_mem[cur_set][w] + 1'b1;
        end
      end
`ifdef INST_CACHE_PERF_EN
      if ((state == LOOKUP) && hit && (perf_hits != 32'hFFFF_FFFF))
        perf_hits <= perf_hits + 32'd1;
      if ((state == LOOKUP) && !hit && (perf_misses != 32'hFFFF_FFFF))
        perf_misses <= perf_misses + 32'd1;
`endif
    end
  end

  // Line storage needs no reset: valid bits gate every read.
  always_ff @(posedge clk) begin
    if (beat)      data_mem[victim][cur_set][cnt] <= mem_rdata;
    if (last_beat) tag_mem[victim][cur_set]       <= cur_tag;
  end

endmodule
